// File: rtl/data_path.sv
// Mini-SRC style single-bus 32-bit datapath: register file, PC/IR/MAR/MDR/Y/Z,
// ALU, CON branch flip-flop and word-addressed RAM, all steered by external strobes.
module data_path #(
    parameter int    MEM_DEPTH = 512,
    parameter string MEM_INIT  = ""
) (
    input  logic clock,
    input  logic clear,
    input  logic MAR_clear,
    input  logic PCout,
    input  logic Zlowout,
    input  logic MDRout,
    input  logic Rout,
    input  logic BAout,
    input  logic Csignout,
    input  logic PCin,
    input  logic IRin,
    input  logic Yin,
    input  logic MARin,
    input  logic MDRin,
    input  logic Zlowin,
    input  logic Zhighin,
    input  logic Rin,
    input  logic Gra,
    input  logic Grb,
    input  logic IncPC,
    input  logic ADD,
    input  logic AND,
    input  logic BRANCH,
    input  logic MD_read,
    input  logic Read,
    input  logic Write,
    input  logic CONin,
    output logic CONFF
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d;
    logic [31:0]   mdr_q, mdr_d, zlo_q, zlo_d, zhi_q, zhi_d;
    logic [AW-1:0] mar_q, mar_d;
    logic          con_q, con_d;
    logic [31:0]   reg_q [16];
    logic [31:0]   reg_d [16];
    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   ram_rdata_q;

    logic [31:0]   bus_s, c_sext_s;
    logic [63:0]   alu_s;
    logic [3:0]    idx_s;
    logic          con_cond_s;
    logic          unused_opcode_s;

    // The opcode is decoded by the external sequencer, not here.
    assign unused_opcode_s = ^ir_q[31:27];
    assign c_sext_s        = {{13{ir_q[18]}}, ir_q[18:0]};
    assign CONFF           = con_q;

    // Register index selection from the IR Ra/Rb fields.
    always_comb begin
        idx_s = 4'd0;
        if (Gra) begin
            idx_s = ir_q[26:23];
        end else if (Grb) begin
            idx_s = ir_q[22:19];
        end else begin
            idx_s = 4'd0;
        end
    end

    // Shared bus multiplexer; BAout reads R0 as zero for base-address addressing.
    always_comb begin
        bus_s = 32'd0;
        if (PCout) begin
            bus_s = pc_q;
        end else if (Zlowout) begin
            bus_s = zlo_q;
        end else if (MDRout) begin
            bus_s = mdr_q;
        end else if (Rout) begin
            bus_s = reg_q[idx_s];
        end else if (BAout) begin
            bus_s = (idx_s == 4'd0) ? 32'd0 : reg_q[idx_s];
        end else if (Csignout) begin
            bus_s = c_sext_s;
        end else begin
            bus_s = 32'd0;
        end
    end

    // ALU with 64-bit result; adds keep their carry in bit 32.
    always_comb begin
        alu_s = 64'd0;
        if (IncPC) begin
            alu_s = {32'd0, bus_s} + 64'd1;
        end else if (BRANCH || ADD) begin
            alu_s = {32'd0, y_q} + {32'd0, bus_s};
        end else if (AND) begin
            alu_s = {32'd0, y_q & bus_s};
        end else begin
            alu_s = 64'd0;
        end
    end

    // Branch condition evaluated on the bus according to C2.
    always_comb begin
        con_cond_s = 1'b0;
        case (ir_q[20:19])
            2'b00:   con_cond_s = (bus_s == 32'd0);
            2'b01:   con_cond_s = (bus_s != 32'd0);
            2'b10:   con_cond_s = (bus_s[31] == 1'b0);
            2'b11:   con_cond_s = (bus_s[31] == 1'b1);
            default: con_cond_s = 1'b0;
        endcase
    end

    // Next-state values for all strobe-loaded registers.
    always_comb begin
        pc_d  = PCin  ? bus_s : pc_q;
        ir_d  = IRin  ? bus_s : ir_q;
        y_d   = Yin   ? bus_s : y_q;
        zlo_d = Zlowin  ? alu_s[31:0]  : zlo_q;
        zhi_d = Zhighin ? alu_s[63:32] : zhi_q;
        con_d = CONin ? con_cond_s : con_q;
        if (MAR_clear) begin
            mar_d = '0;
        end else if (MARin) begin
            mar_d = bus_s[AW-1:0];
        end else begin
            mar_d = mar_q;
        end
        if (MDRin) begin
            mdr_d = MD_read ? ram_rdata_q : bus_s;
        end else begin
            mdr_d = mdr_q;
        end
        reg_d = reg_q;
        if (Rin) begin
            reg_d[idx_s] = bus_s;
        end else begin
            reg_d[idx_s] = reg_q[idx_s];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= 32'd0;
            ir_q  <= 32'd0;
            y_q   <= 32'd0;
            mar_q <= '0;
            mdr_q <= 32'd0;
            zlo_q <= 32'd0;
            zhi_q <= 32'd0;
            con_q <= 1'b0;
            reg_q <= '{default: 32'd0};
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            zlo_q <= zlo_d;
            zhi_q <= zhi_d;
            con_q <= con_d;
            reg_q <= reg_d;
        end
    end

    // RAM keeps its contents through reset; strobes are gated while clear is low.
    always_ff @(posedge clock) begin
        if (clear) begin
            if (Write) begin
                mem[mar_q] <= mdr_q;
            end
            if (Read) begin
                ram_rdata_q <= mem[mar_q];
            end
        end
    end

    // RAM image starts all-zero.
    initial begin
        for (int k = 0; k < MEM_DEPTH; k++) begin
            mem[k] = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed program from the test plan plus random strobes,
// checked every cycle against a behavioural model of the datapath.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [24:0] s_in  = 25'd0;
    logic        conff;

    localparam logic [24:0] S_MARCLR = 25'd1 << 0,  S_PCOUT  = 25'd1 << 1,
                            S_ZLOUT  = 25'd1 << 2,  S_MDROUT = 25'd1 << 3,
                            S_ROUT   = 25'd1 << 4,  S_BAOUT  = 25'd1 << 5,
                            S_CSOUT  = 25'd1 << 6,  S_PCIN   = 25'd1 << 7,
                            S_IRIN   = 25'd1 << 8,  S_YIN    = 25'd1 << 9,
                            S_MARIN  = 25'd1 << 10, S_MDRIN  = 25'd1 << 11,
                            S_ZLIN   = 25'd1 << 12, S_ZHIN   = 25'd1 << 13,
                            S_RIN    = 25'd1 << 14, S_GRA    = 25'd1 << 15,
                            S_GRB    = 25'd1 << 16, S_INC    = 25'd1 << 17,
                            S_ADD    = 25'd1 << 18, S_AND    = 25'd1 << 19,
                            S_BR     = 25'd1 << 20, S_MDRD   = 25'd1 << 21,
                            S_READ   = 25'd1 << 22, S_WRITE  = 25'd1 << 23,
                            S_CONIN  = 25'd1 << 24;

    data_path dut (
        .clock(clock), .clear(clear), .MAR_clear(s_in[0]),
        .PCout(s_in[1]), .Zlowout(s_in[2]), .MDRout(s_in[3]), .Rout(s_in[4]),
        .BAout(s_in[5]), .Csignout(s_in[6]), .PCin(s_in[7]), .IRin(s_in[8]),
        .Yin(s_in[9]), .MARin(s_in[10]), .MDRin(s_in[11]), .Zlowin(s_in[12]),
        .Zhighin(s_in[13]), .Rin(s_in[14]), .Gra(s_in[15]), .Grb(s_in[16]),
        .IncPC(s_in[17]), .ADD(s_in[18]), .AND(s_in[19]), .BRANCH(s_in[20]),
        .MD_read(s_in[21]), .Read(s_in[22]), .Write(s_in[23]), .CONin(s_in[24]),
        .CONFF(conff)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_y, m_mdr, m_zlo, m_zhi, m_rd;
    logic [8:0]  m_mar;
    logic        m_con;
    logic [31:0] m_r [16];
    logic [31:0] m_ram [512];
    bit          m_wr [512];
    bit          m_rd_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [24:0] s);
        if (s[15]) return int'(m_ir[26:23]);
        if (s[16]) return int'(m_ir[22:19]);
        return 0;
    endfunction

    function automatic logic [31:0] m_const();
        logic [31:0] c;
        c = {13'd0, m_ir[18:0]};
        if (m_ir[18]) c = c - 32'h0008_0000;
        return c;
    endfunction

    function automatic logic [31:0] m_bus(input logic [24:0] s);
        logic [31:0] src [6];
        int          i;
        i = m_idx(s);
        src = '{m_pc, m_zlo, m_mdr, m_r[i], (i == 0) ? 32'd0 : m_r[i], m_const()};
        for (int k = 0; k < 6; k++) begin
            if (s[k+1]) return src[k];
        end
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_pc = 0; m_ir = 0; m_y = 0; m_mdr = 0; m_zlo = 0; m_zhi = 0;
        m_mar = 0; m_con = 0;
        for (int k = 0; k < 16; k++) m_r[k] = 0;
    endtask

    task automatic m_step(input logic [24:0] s);
        logic [31:0] b, old_rd;
        logic [63:0] r;
        logic        cnd;
        int          i;
        b = m_bus(s);
        i = m_idx(s);
        if (s[17])              r = 64'(b) + 64'd1;
        else if (s[20] || s[18]) r = 64'(b) + 64'(m_y);
        else if (s[19])         r = 64'(b & m_y);
        else                    r = 64'd0;
        case (m_ir[20:19])
            2'd0:    cnd = (b == 0);
            2'd1:    cnd = (b != 0);
            2'd2:    cnd = ($signed(b) >= 0);
            default: cnd = ($signed(b) < 0);
        endcase
        old_rd = m_rd;
        if (s[22]) begin
            m_rd = m_ram[m_mar];
            m_rd_valid = m_wr[m_mar];
        end
        if (s[23]) begin
            m_ram[m_mar] = m_mdr;
            m_wr[m_mar] = 1'b1;
        end
        if (s[11]) m_mdr = s[21] ? old_rd : b;
        if (s[0])       m_mar = 9'd0;
        else if (s[10]) m_mar = b[8:0];
        if (s[7])  m_pc  = b;
        if (s[8])  m_ir  = b;
        if (s[9])  m_y   = b;
        if (s[12]) m_zlo = r[31:0];
        if (s[13]) m_zhi = r[63:32];
        if (s[14]) m_r[i] = b;
        if (s[24]) m_con = cnd;
    endtask

    // Model advances on the same edges as the design.
    always @(posedge clock or negedge clear) begin
        if (!clear) m_reset();
        else        m_step(s_in);
    end

    // Every-cycle comparison of the design against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("pc", dut.pc_q, m_pc);
            chk("ir", dut.ir_q, m_ir);
            chk("y", dut.y_q, m_y);
            chk("mar", dut.mar_q, m_mar);
            chk("mdr", dut.mdr_q, m_mdr);
            chk("zlow", dut.zlo_q, m_zlo);
            chk("zhigh", dut.zhi_q, m_zhi);
            chk("conff", conff, m_con);
            chk("bus", dut.bus_s, m_bus(s_in));
            for (int k = 0; k < 16; k++) chk($sformatf("r%0d", k), dut.reg_q[k], m_r[k]);
            if (m_rd_valid) chk("rdata", dut.ram_rdata_q, m_rd);
        end
    end

    task automatic st(input logic [24:0] m);
        s_in = m;
        @(posedge clock);
        #1;
        s_in = 25'd0;
    endtask

    // Build an arbitrary value in Zlow by doubling and incrementing.
    task automatic set_z(input logic [31:0] v);
        bit started;
        started = 1'b0;
        st(S_ZLIN);
        for (int i = 31; i >= 0; i--) begin
            if (started) begin
                st(S_ZLOUT | S_YIN);
                st(S_ZLOUT | S_ADD | S_ZLIN);
            end
            if (v[i]) begin
                st(S_ZLOUT | S_INC | S_ZLIN);
                started = 1'b1;
            end
        end
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        set_z(a);
        st(S_ZLOUT | S_MARIN);
        set_z(d);
        st(S_ZLOUT | S_MDRIN);
        st(S_WRITE);
    endtask

    task automatic fetch();
        st(S_PCOUT | S_MARIN | S_INC | S_ZLIN);
        st(S_ZLOUT | S_PCIN | S_READ);
        st(S_MDRD | S_MDRIN);
        st(S_MDROUT | S_IRIN);
    endtask

    initial begin
        logic [24:0] m;
        m_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear = 1'b1;
        cmp_en = 1'b1;
        chk("reset_pc", dut.pc_q, 32'd0);
        chk("reset_conff", conff, 1'b0);
        chk("reset_bus", dut.bus_s, 32'd0);

        load_word(32'd0, 32'h6100_0005);
        load_word(32'd1, 32'h9100_0003);
        load_word(32'd2, 32'h9108_0003);
        st(S_ZLOUT | S_RIN);

        // ldi R2, 5
        fetch();
        chk("ldi_ir", dut.ir_q, 32'h6100_0005);
        chk("ldi_pc", dut.pc_q, 32'd1);
        st(S_GRB | S_BAOUT | S_YIN);
        chk("ldi_y_ba_r0", dut.y_q, 32'd0);
        st(S_CSOUT | S_ADD | S_ZLIN);
        chk("ldi_zlow", dut.zlo_q, 32'd5);
        st(S_ZLOUT | S_GRA | S_RIN);
        chk("ldi_r2", dut.reg_q[2], 32'd5);

        // brzr R2, 3 (not taken)
        fetch();
        chk("brzr_pc", dut.pc_q, 32'd2);
        st(S_GRA | S_ROUT | S_CONIN);
        chk("brzr_con", conff, 1'b0);
        st(S_PCOUT | S_YIN);
        st(S_CSOUT | S_BR | S_ZLIN);
        chk("brzr_zlow", dut.zlo_q, 32'd5);
        st(S_ZLOUT);
        chk("brzr_pc_hold", dut.pc_q, 32'd2);

        // brnz R2, 3 (taken)
        fetch();
        st(S_GRA | S_ROUT | S_CONIN);
        chk("brnz_con", conff, 1'b1);
        st(S_PCOUT | S_YIN);
        st(S_CSOUT | S_BR | S_ZLIN);
        chk("brnz_zlow", dut.zlo_q, 32'd6);
        st(S_ZLOUT | S_PCIN);
        chk("brnz_pc", dut.pc_q, 32'd6);

        // Negative constant, AND, and add carry
        load_word(32'd6, 32'h0007_FFFF);
        fetch();
        set_z(32'h0000_F0F0);
        st(S_ZLOUT | S_YIN);
        st(S_CSOUT | S_AND | S_ZLIN);
        chk("and_zlow", dut.zlo_q, 32'h0000_F0F0);
        s_in = S_CSOUT | S_YIN;
        #1;
        chk("csign_bus", dut.bus_s, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        s_in = 25'd0;
        st(S_INC | S_ZLIN);
        st(S_ZLOUT | S_ADD | S_ZLIN | S_ZHIN);
        chk("carry_zlow", dut.zlo_q, 32'd0);
        chk("carry_zhigh", dut.zhi_q, 32'd1);

        // MAR clear, RAM write/read, mid-cycle reset
        st(S_MARCLR | S_MARIN | S_PCOUT);
        chk("mar_clear", dut.mar_q, 32'd0);
        load_word(32'd7, 32'hDEAD_BEEF);
        st(S_READ);
        chk("ram_read", dut.ram_rdata_q, 32'hDEAD_BEEF);
        set_z(32'h1234_5678);
        st(S_ZLOUT | S_MDRIN);
        st(S_READ | S_WRITE);
        chk("ram_rw_old", dut.ram_rdata_q, 32'hDEAD_BEEF);
        st(S_READ);
        chk("ram_rw_new", dut.ram_rdata_q, 32'h1234_5678);
        clear = 1'b0;
        #1;
        chk("async_pc", dut.pc_q, 32'd0);
        chk("async_ir", dut.ir_q, 32'd0);
        chk("async_conff", conff, 1'b0);
        @(posedge clock); #1;
        clear = 1'b1;
        set_z(32'd7);
        st(S_ZLOUT | S_MARIN);
        st(S_READ);
        st(S_MDRD | S_MDRIN);
        chk("ram_kept", dut.mdr_q, 32'h1234_5678);

        // Random strobes with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            m = 25'($urandom) & 25'($urandom);
            if (!m_wr[m_mar]) m[22] = 1'b0;
            clear = ($urandom_range(0, 63) != 0);
            s_in = m;
            @(posedge clock); #1;
        end
        clear = 1'b1;
        s_in = 25'd0;
        @(posedge clock); #1;
        @(negedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
